qbus_switch_display: RTL and testbench

- Parametrised successor of the single console switch register: NCHAN channels, each a read-only switch word plus a write-only display latch, with a CSR per channel.
- Switch inputs are synchronised and debounced; a debounced change sets a per-channel flag and can raise a vectored QBUS interrupt.
- Sits on the QBUS I/O page beside other slave devices and shares the latched-address, data-line and pulse interface used by them.

---
 rtl/qbus_pkg.sv | 42 ++++
 rtl/switch_debounce.sv | 59 +++++
 rtl/qbus_switch_display.sv | 238 +++++++++++++++++++++++
 tb/tb_qbus_switch_display.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// Shared definitions for the QBUS switch/display block: CSR bit positions,
// register offsets inside a channel, channel stride, default base address,
// the interrupt-grant state type and small helpers for CSR and vector words.
package qbus_pkg;

   // CSR bit positions
   localparam int CSR_CHG_BIT = 7;
   localparam int CSR_IE_BIT  = 6;
   localparam int CSR_RBK_BIT = 0;

   // Register offsets inside one channel (bit 0 is the byte select)
   localparam logic [1:0] REG_DATA_OFF = 2'd0;
   localparam logic [1:0] REG_CSR_OFF  = 2'd2;

   // Byte distance between consecutive channels
   localparam int CHAN_STRIDE = 4;

   // Conventional console switch register address
   localparam logic [17:0] DEFAULT_BASE_ADDR = 18'o777570;

   // Interrupt acknowledge state
   typedef enum logic {
      GRANT_IDLE   = 1'b0,
      GRANT_ACTIVE = 1'b1
   } grant_state_t;

   // Read value of a channel CSR
   function automatic logic [15:0] csr_word(input logic chg, input logic ie, input logic rbk);
      logic [15:0] word;
      word              = '0;
      word[CSR_CHG_BIT] = chg;
      word[CSR_IE_BIT]  = ie;
      word[CSR_RBK_BIT] = rbk;
      return word;
   endfunction

   // Interrupt vector presented for a given channel
   function automatic logic [15:0] vector_for(input logic [8:0] base, input logic [1:0] ch);
      return 16'(base) + {12'd0, ch, 2'b00};
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// One 16-bit switch channel: two-flop synchroniser, candidate register and
// stability counter. The debounced word is accepted on the cycle the counter
// reaches its saturation value, so a clean input change appears on o_sw_db
// DEBOUNCE_CYCLES + 2 clocks after it is first sampled. o_change pulses for
// exactly that cycle.
module switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_raw,
   output logic [15:0] o_sw_db,
   output logic        o_change
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEBOUNCE_CYCLES - 2);

   logic [15:0]   r_sync1;
   logic [15:0]   r_sync2;
   logic [15:0]   r_cand;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_db;

   logic w_stable;
   logic w_accept;

   // Candidate is unchanged this cycle and the counter is about to saturate
   assign w_stable = (r_sync2 == r_cand);
   assign w_accept = w_stable && (r_cnt >= CNT_ACCEPT) && (r_cand != r_db);

   // Synchroniser, candidate tracking, saturating counter and acceptance
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_cand  <= '0;
         r_cnt   <= '0;
         r_db    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (!w_stable) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_accept) begin
            r_db <= r_cand;
         end
      end
   end

   assign o_sw_db  = r_db;
   assign o_change = w_accept;

endmodule

// File: rtl/qbus_switch_display.sv
// Multi-channel QBUS console switch / display register block.
// Each channel has a DATA register (read: debounced switches, write: display
// latch) and a CSR (bit7 CHG, bit6 IE). A debounced switch change sets CHG;
// a 0->1 transition of CHG&IE arms a vectored interrupt, channel k using
// vector + 4k. Optional readback (bit0 RBK) is built when the macro
// QBUS_SWITCH_DISPLAY_READBACK_EN is defined.
//
// Interrupt handshake: assert_vector is held high by the bus master for the
// whole acknowledge. On its first high cycle with irq set, the lowest pending
// channel is granted and its vector driven on TDL for as long as
// assert_vector stays high; when assert_vector drops, that channel's pending
// bit clears (or re-arms if CHG&IE rose again meanwhile) and the grant ends.
module qbus_switch_display
   import qbus_pkg::*;
#(
   parameter int NCHAN           = 1,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic                 qclk,
   input  logic                 reset,
   input  logic [21:0]          RAL,
   input  logic                 RBS7,
   input  logic [15:0]          RDL,
   output logic [15:0]          TDL,
   input  logic [17:0]          addr,
   input  logic [8:0]           vector,
   output logic                 addr_match,
   input  logic                 assert_vector,
   input  logic                 write_pulse,
   input  logic                 write_byte,
   input  logic                 read_pulse,
   input  logic [16*NCHAN-1:0]  switches,
   output logic [16*NCHAN-1:0]  display,
   output logic                 irq,
   output logic                 o_dbg_grant_state,
   output logic [1:0]           o_dbg_grant_ch
);

   // Address decode
   logic [12:0] w_off;
   logic [1:0]  w_ch;
   logic [1:0]  w_reg_off;
   logic        w_is_data;
   logic        w_is_csr;
   logic        w_lane_lo;
   logic        w_lane_hi;
   logic        w_unused;

   // Per-channel state
   logic [15:0]      r_display [NCHAN];
   logic [NCHAN-1:0] r_chg;
   logic [NCHAN-1:0] r_ie;
   logic [NCHAN-1:0] r_pend;
   logic [NCHAN-1:0] r_rearm;
   logic [NCHAN-1:0] r_cie_q;
   logic [NCHAN-1:0] w_rbk;
`ifdef QBUS_SWITCH_DISPLAY_READBACK_EN
   logic [NCHAN-1:0] r_rbk;
`endif

   // Per-channel strobes
   logic [15:0]      w_sw_db [NCHAN];
   logic [NCHAN-1:0] w_sw_change;
   logic [NCHAN-1:0] w_sel;
   logic [NCHAN-1:0] w_data_wr;
   logic [NCHAN-1:0] w_csr_wr;
   logic [NCHAN-1:0] w_chg_clr;
   logic [NCHAN-1:0] w_cie;
   logic [NCHAN-1:0] w_rise;

   // Grant handshake
   grant_state_t r_state;
   logic [1:0]   r_grant_ch;
   logic         r_av_q;
   logic [1:0]   w_low_ch;
   logic         w_take;
   logic         w_release;
   logic [15:0]  w_reg_rd;

   assign w_off      = RAL[12:0] - addr[12:0];
   assign addr_match = RBS7 && (w_off < 13'(CHAN_STRIDE * NCHAN));
   assign w_ch       = w_off[3:2];
   assign w_reg_off  = {w_off[1], 1'b0};
   assign w_is_data  = (w_reg_off == REG_DATA_OFF);
   assign w_is_csr   = (w_reg_off == REG_CSR_OFF);
   assign w_lane_lo  = !write_byte || !RAL[0];
   assign w_lane_hi  = !write_byte || RAL[0];
   assign w_unused   = ^{RAL[21:13], addr[17:13]};

`ifdef QBUS_SWITCH_DISPLAY_READBACK_EN
   assign w_rbk = r_rbk;
`else
   assign w_rbk = '0;
`endif

   // One debouncer per channel; display latches fan out to the port
   for (genvar g = 0; g < NCHAN; g++) begin : g_chan
      switch_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .i_clk    (qclk),
         .i_reset  (reset),
         .i_raw    (switches[16*g +: 16]),
         .o_sw_db  (w_sw_db[g]),
         .o_change (w_sw_change[g])
      );
      assign display[16*g +: 16] = r_display[g];
   end

   // Channel select and register access strobes
   always_comb begin
      w_sel     = '0;
      w_data_wr = '0;
      w_csr_wr  = '0;
      w_chg_clr = '0;
      for (int k = 0; k < NCHAN; k++) begin
         w_sel[k]     = addr_match && (w_ch == 2'(k));
         w_data_wr[k] = write_pulse && w_sel[k] && w_is_data;
         // A high-byte CSR write touches no implemented bit
         w_csr_wr[k]  = write_pulse && w_sel[k] && w_is_csr && w_lane_lo;
         w_chg_clr[k] = read_pulse && w_sel[k] && w_is_data && !w_rbk[k];
      end
   end

   assign w_cie  = r_chg & r_ie;
   assign w_rise = w_cie & ~r_cie_q;

   // Lowest-numbered pending channel wins the acknowledge
   always_comb begin
      w_low_ch = '0;
      for (int k = NCHAN - 1; k >= 0; k--) begin
         if (r_pend[k]) w_low_ch = 2'(k);
      end
   end

   assign irq       = |r_pend;
   assign w_take    = (r_state == GRANT_IDLE) && assert_vector && !r_av_q && irq;
   assign w_release = (r_state == GRANT_ACTIVE) && !assert_vector;

   // Display latches, CSR bits and change flags
   always_ff @(posedge qclk) begin
      if (reset) begin
         for (int k = 0; k < NCHAN; k++) r_display[k] <= '0;
         r_chg <= '0;
         r_ie  <= '0;
`ifdef QBUS_SWITCH_DISPLAY_READBACK_EN
         r_rbk <= '0;
`endif
      end else begin
         for (int k = 0; k < NCHAN; k++) begin
            if (w_data_wr[k]) begin
               if (w_lane_lo) r_display[k][7:0]  <= RDL[7:0];
               if (w_lane_hi) r_display[k][15:8] <= RDL[15:8];
            end
            if (w_csr_wr[k]) begin
               r_ie[k] <= RDL[CSR_IE_BIT];
`ifdef QBUS_SWITCH_DISPLAY_READBACK_EN
               r_rbk[k] <= RDL[CSR_RBK_BIT];
`endif
            end
            // A new change beats a coincident read clear
            if (w_sw_change[k])    r_chg[k] <= 1'b1;
            else if (w_chg_clr[k]) r_chg[k] <= 1'b0;
         end
      end
   end

   // Interrupt pending bits with re-arm while the channel is being acknowledged
   always_ff @(posedge qclk) begin
      if (reset) begin
         r_pend  <= '0;
         r_rearm <= '0;
         r_cie_q <= '0;
      end else begin
         r_cie_q <= w_cie;
         for (int k = 0; k < NCHAN; k++) begin
            if (w_csr_wr[k] && !RDL[CSR_IE_BIT]) begin
               r_pend[k]  <= 1'b0;
               r_rearm[k] <= 1'b0;
            end else if (w_release && (r_grant_ch == 2'(k))) begin
               r_pend[k]  <= r_rearm[k] | w_rise[k];
               r_rearm[k] <= 1'b0;
            end else if ((r_state == GRANT_ACTIVE) && (r_grant_ch == 2'(k)) && w_rise[k]) begin
               r_rearm[k] <= 1'b1;
            end else if (w_rise[k]) begin
               r_pend[k] <= 1'b1;
            end
         end
      end
   end

   // Grant state machine
   always_ff @(posedge qclk) begin
      if (reset) begin
         r_state    <= GRANT_IDLE;
         r_grant_ch <= '0;
         r_av_q     <= 1'b0;
      end else begin
         r_av_q <= assert_vector;
         case (r_state)
            GRANT_IDLE: begin
               if (w_take) begin
                  r_grant_ch <= w_low_ch;
                  r_state    <= GRANT_ACTIVE;
               end
            end
            GRANT_ACTIVE: begin
               if (!assert_vector) r_state <= GRANT_IDLE;
            end
            default: r_state <= GRANT_IDLE;
         endcase
      end
   end

   assign o_dbg_grant_state = r_state;
   assign o_dbg_grant_ch    = r_grant_ch;

   // Selected register read value
   always_comb begin
      w_reg_rd = '0;
      for (int k = 0; k < NCHAN; k++) begin
         if (w_ch == 2'(k)) begin
            if (w_is_csr)      w_reg_rd = csr_word(r_chg[k], r_ie[k], w_rbk[k]);
            else if (w_rbk[k]) w_reg_rd = r_display[k];
            else               w_reg_rd = w_sw_db[k];
         end
      end
   end

   // Bus data out: vector during acknowledge, else decoded register, else 0
   always_comb begin
      if ((r_state == GRANT_ACTIVE) && assert_vector) TDL = vector_for(vector, r_grant_ch);
      else if (w_take)                                TDL = vector_for(vector, w_low_ch);
      else if (addr_match)                            TDL = w_reg_rd;
      else                                            TDL = '0;
   end

endmodule

// File: tb/tb_qbus_switch_display.sv
// Bench for qbus_switch_display (NCHAN=2, DEBOUNCE_CYCLES=8). Driver tasks
// push expected values into a queue tagged with the cycle they apply to; a
// monitor on the falling clock edge pops and compares them.
module tb_qbus_switch_display;
   import qbus_pkg::*;

   localparam int NCH = 2;
   localparam int DEB = 8;
   localparam logic [8:0] VEC = 9'o300;
   localparam int K_TDL = 0, K_MATCH = 1, K_IRQ = 2, K_DISP = 3;

   logic        qclk = 1'b0;
   logic        reset;
   logic [21:0] RAL;
   logic        RBS7;
   logic [15:0] RDL;
   logic [15:0] TDL;
   logic [17:0] addr;
   logic [8:0]  vector;
   logic        addr_match;
   logic        assert_vector;
   logic        write_pulse;
   logic        write_byte;
   logic        read_pulse;
   logic [31:0] switches;
   logic [31:0] display;
   logic        irq;
   logic        dbg_state;
   logic [1:0]  dbg_ch;

   qbus_switch_display #(
      .NCHAN           (NCH),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .qclk              (qclk),
      .reset             (reset),
      .RAL               (RAL),
      .RBS7              (RBS7),
      .RDL               (RDL),
      .TDL               (TDL),
      .addr              (addr),
      .vector            (vector),
      .addr_match        (addr_match),
      .assert_vector     (assert_vector),
      .write_pulse       (write_pulse),
      .write_byte        (write_byte),
      .read_pulse        (read_pulse),
      .switches          (switches),
      .display           (display),
      .irq               (irq),
      .o_dbg_grant_state (dbg_state),
      .o_dbg_grant_ch    (dbg_ch)
   );

   // Clock and cycle counter
   always #5 qclk = ~qclk;

   int unsigned cyc = 0;
   always @(posedge qclk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   // Scoreboard
   typedef struct {
      int unsigned cyc;
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_cur;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] act;

   always @(negedge qclk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e_cur = exp_q.pop_front();
         case (e_cur.kind)
            K_TDL:   act = {16'h0, TDL};
            K_MATCH: act = {31'h0, addr_match};
            K_IRQ:   act = {31'h0, irq};
            default: act = display;
         endcase
         checks++;
         if (act !== e_cur.val) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0o, expected %0o",
                     (e_cur.kind == K_TDL) ? "TDL" : (e_cur.kind == K_MATCH) ? "addr_match" :
                     (e_cur.kind == K_IRQ) ? "irq" : "display", cyc, act, e_cur.val);
         end
      end
   end

   // Reference model
   logic [15:0] m_disp [NCH];
   logic [15:0] m_swdb [NCH];
   bit          m_chg  [NCH];
   bit          m_ie   [NCH];
   bit          m_rbk  [NCH];

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_disp[k] = '0; m_swdb[k] = '0; m_chg[k] = 0; m_ie[k] = 0; m_rbk[k] = 0;
      end
   endtask

   function automatic logic [15:0] m_data(input int ch);
      return m_rbk[ch] ? m_disp[ch] : m_swdb[ch];
   endfunction

   function automatic logic [15:0] m_csr(input int ch);
      logic [15:0] r;
      r    = '0;
      r[7] = m_chg[ch];
      r[6] = m_ie[ch];
      r[0] = m_rbk[ch];
      return r;
   endfunction

   // Driver tasks
   task automatic tick();
      @(posedge qclk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input int kind, input logic [31:0] v);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   function automatic logic [21:0] reg_addr(input int ch, input bit csr, input bit hi);
      return 22'(DEFAULT_BASE_ADDR) + 22'(4 * ch + (csr ? 2 : 0) + (hi ? 1 : 0));
   endfunction

   task automatic wr(input int ch, input bit csr, input logic [15:0] d, input bit bytew, input bit hi);
      RAL = reg_addr(ch, csr, hi); RBS7 = 1'b1; RDL = d;
      write_byte = bytew; write_pulse = 1'b1;
      chk(K_MATCH, 1);
      tick();
      write_pulse = 1'b0; write_byte = 1'b0; RBS7 = 1'b0; RDL = '0;
      if (!csr) begin
         if (!bytew || !hi) m_disp[ch][7:0]  = d[7:0];
         if (!bytew || hi)  m_disp[ch][15:8] = d[15:8];
      end else if (!(bytew && hi)) begin
         m_ie[ch] = d[6];
`ifdef QBUS_SWITCH_DISPLAY_READBACK_EN
         m_rbk[ch] = d[0];
`endif
      end
   endtask

   task automatic rd(input int ch, input bit csr, input bit pulse);
      RAL = reg_addr(ch, csr, 0); RBS7 = 1'b1; read_pulse = pulse;
      chk(K_TDL, {16'h0, csr ? m_csr(ch) : m_data(ch)});
      chk(K_MATCH, 1);
      tick();
      read_pulse = 1'b0; RBS7 = 1'b0;
      if (pulse && !csr && !m_rbk[ch]) m_chg[ch] = 0;
   endtask

   task automatic probe(input logic [21:0] a, input bit rbs);
      RAL = a; RBS7 = rbs;
      chk(K_MATCH, 0);
      chk(K_TDL, 0);
      tick();
      RBS7 = 1'b0;
   endtask

   // Apply a stable switch word and wait out the debounce latency
   task automatic settle(input int ch, input logic [15:0] v);
      switches[16*ch +: 16] = v;
      idle(DEB + 2);
      if (v != m_swdb[ch]) begin
         m_swdb[ch] = v;
         m_chg[ch]  = 1;
      end
   endtask

   // Stimulus
   initial begin
      logic [15:0] d;
      int          ch, op;
      bit          bw, hi;

      reset = 1'b1; RAL = '0; RBS7 = 1'b0; RDL = '0;
      addr = DEFAULT_BASE_ADDR; vector = VEC;
      assert_vector = 1'b0; write_pulse = 1'b0; write_byte = 1'b0; read_pulse = 1'b0;
      switches = '0;
      model_reset();
      idle(3);
      chk(K_TDL, 0); chk(K_IRQ, 0); chk(K_DISP, 0); chk(K_MATCH, 0);
      reset = 1'b0;
      tick();
      probe(22'o777570, 0);

      // Decode and byte lanes
      wr(1, 0, 16'o052525, 0, 0);
      wr(1, 0, 16'o177400, 1, 1);
      chk(K_DISP, {16'o177525, 16'o000000});
      probe(22'o777600, 1);
      probe(22'o777566, 1);
      wr(0, 0, 16'o012253, 1, 0);
      chk(K_DISP, {16'o177525, 16'o000253});
      wr(0, 1, 16'o177777, 1, 1);
      rd(0, 1, 0);
      rd(1, 1, 0);

      // Debounce: glitching input never accepted
      for (int i = 0; i < 25; i++) begin
         switches[15:0] = (i % 5 == 4) ? 16'o0 : 16'o17;
         rd(0, 0, 0);
      end
      switches[15:0] = 16'o17;
      for (int j = 0; j < 12; j++) begin
         if (j == DEB + 2) begin
            m_swdb[0] = 16'o17;
            m_chg[0]  = 1;
         end
         rd(0, 0, 0);
      end
      rd(0, 1, 0);

      // CHG clear, then clear colliding with a new change
      rd(0, 0, 1);
      rd(0, 1, 0);
      switches[15:0] = 16'o0;
      idle(DEB + 1);
      rd(0, 0, 1);
      m_swdb[0] = 16'o0;
      m_chg[0]  = 1;
      rd(0, 1, 0);
      rd(0, 0, 0);

      // Interrupt priority across two channels
      settle(1, 16'($urandom_range(1, 65535)));
      wr(0, 1, 16'o000100, 0, 0);
      wr(1, 1, 16'o000100, 0, 0);
      idle(2);
      chk(K_IRQ, 1);
      assert_vector = 1'b1;
      repeat (3) begin chk(K_TDL, 16'o300); tick(); end
      assert_vector = 1'b0;
      chk(K_TDL, 0);
      tick();
      chk(K_IRQ, 1);
      tick();
      assert_vector = 1'b1;
      repeat (3) begin chk(K_TDL, 16'o304); tick(); end
      assert_vector = 1'b0;
      tick();
      chk(K_IRQ, 0);
      // Acknowledge with nothing pending: normal decode
      assert_vector = 1'b1;
      chk(K_IRQ, 0);
      rd(1, 0, 0);
      assert_vector = 1'b0;
      tick();

      // IE gating
      wr(1, 1, 16'o000000, 0, 0);
      wr(0, 1, 16'o000000, 0, 0);
      chk(K_IRQ, 0);
      wr(0, 1, 16'o000100, 0, 0);
      chk(K_IRQ, 0);
      tick();
      chk(K_IRQ, 1);
      wr(0, 1, 16'o000000, 0, 0);
      chk(K_IRQ, 0);

      // Randomised register traffic, interrupts kept disabled
      for (int n = 0; n < 40; n++) begin
         ch = $urandom_range(0, 1);
         op = $urandom_range(0, 5);
         d  = 16'($urandom);
         bw = 1'($urandom_range(0, 1));
         hi = bw ? 1'($urandom_range(0, 1)) : 1'b0;
         case (op)
            0: wr(ch, 0, d, 0, 0);
            1: wr(ch, 0, d, 1, 1'($urandom_range(0, 1)));
            2: wr(ch, 1, d & 16'o177677, bw, hi);
            3: rd(ch, 0, 1'($urandom_range(0, 1)));
            4: rd(ch, 1, 0);
            default: probe(22'(DEFAULT_BASE_ADDR) + 22'($urandom_range(8, 200)), 1);
         endcase
         chk(K_DISP, {m_disp[1], m_disp[0]});
         chk(K_IRQ, 0);
      end

`ifdef QBUS_SWITCH_DISPLAY_READBACK_EN
      // Readback: DATA returns the display latch and read_pulse keeps CHG
      settle(1, ~m_swdb[1]);
      wr(1, 1, 16'o000001, 0, 0);
      rd(1, 0, 1);
      rd(1, 1, 0);
      wr(1, 1, 16'o000000, 0, 0);
      rd(1, 1, 0);
`endif

      // Reset in the middle of an acknowledge
      settle(0, m_swdb[0] ^ 16'o000123);
      wr(0, 1, 16'o000100, 0, 0);
      idle(2);
      chk(K_IRQ, 1);
      assert_vector = 1'b1;
      chk(K_TDL, 16'o300);
      tick();
      chk(K_TDL, 16'o300);
      reset = 1'b1;
      tick();
      model_reset();
      chk(K_TDL, 0); chk(K_IRQ, 0); chk(K_DISP, 0);
      reset = 1'b0;
      assert_vector = 1'b0;
      tick();
      chk(K_TDL, 0); chk(K_MATCH, 0); chk(K_IRQ, 0);

      // Final report
      idle(2);
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard: %0d expectations left unchecked, required 0", exp_q.size());
         errors += exp_q.size();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
